// File: rtl/core_run_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module      : core_run_ctrl_if
// Description : Signal bundle between a worker core's launch responder and the
//               launch controller / core. The master modport drives start and
//               the core status inputs; the slave modport is the responder.
//   Launch side : cpu_start, cpu_start_adr -> ; <- cpu_end, busy, run_cycles,
//                 start_drop, wdog_timeout
//   Core side   : core_halt, mem_busy -> ; <- core_pc_load, core_pc_value,
//                 core_run
// Revision    : 1.0 - initial release
//==============================================================================
interface core_run_ctrl_if #(
    parameter int PC_W = 16
);
    logic            cpu_start;
    logic [PC_W-1:0] cpu_start_adr;
    logic            cpu_end;
    logic            busy;
    logic [31:0]     run_cycles;
    logic            start_drop;
    logic            wdog_timeout;
    logic            core_halt;
    logic            mem_busy;
    logic            core_pc_load;
    logic [PC_W-1:0] core_pc_value;
    logic            core_run;

    modport master (
        output cpu_start, cpu_start_adr, core_halt, mem_busy,
        input  cpu_end, busy, run_cycles, start_drop, wdog_timeout,
               core_pc_load, core_pc_value, core_run
    );

    modport slave (
        input  cpu_start, cpu_start_adr, core_halt, mem_busy,
        output cpu_end, busy, run_cycles, start_drop, wdog_timeout,
               core_pc_load, core_pc_value, core_run
    );
endinterface
`default_nettype wire

// File: rtl/core_run_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : core_run_ctrl
// Description : Per-core launch responder. Accepts a one-cycle start with a
//               start address, strobes the core PC load, enables execution
//               until the core halts, drains for at least FLUSH_CYC cycles and
//               until memory traffic is idle, then returns a one-cycle cpu_end.
// Ports       : clk, rst (asynchronous, active high)
//               bus : core_run_ctrl_if.slave (launch + core signals)
// Parameters  : PC_W       - PC / start address width
//               FLUSH_CYC  - minimum drain cycles after halt (1..15)
//               WDOG_LIMIT - maximum RUN cycles (watchdog build only)
// Options     : CORE_WDOG_EN - build the RUN-cycle watchdog; otherwise
//               wdog_timeout is tied low and RUN exits only on core_halt.
// Revision    : 1.0 - initial release
//==============================================================================
module core_run_ctrl #(
    parameter int PC_W       = 16,
    parameter int FLUSH_CYC  = 3,
    parameter int WDOG_LIMIT = 65535
) (
    input  wire logic      clk,
    input  wire logic      rst,
    core_run_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0]  C_FLUSH_INIT = 4'(FLUSH_CYC);
    localparam logic [31:0] C_RUN_MAX    = 32'hFFFF_FFFF;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_adr_q;
    logic [3:0]      r_flush_cnt;
    logic [3:0]      w_flush_dec;
    logic [31:0]     r_run_cycles;
    logic            r_start_drop;
    logic            w_accept;
    logic            w_enter_flush;
    logic            w_wdog_hit;

    // Count value after this FLUSH cycle; leaving FLUSH is decided on the
    // post-decrement value so that FLUSH lasts exactly FLUSH_CYC cycles.
    assign w_flush_dec = (r_flush_cnt == 4'd0) ? 4'd0 : r_flush_cnt - 4'd1;

`ifdef CORE_WDOG_EN
    localparam logic [32:0] C_WDOG_LIMIT = 33'(WDOG_LIMIT);
    logic r_wdog_timeout;
    logic w_wdog_fire;

    // Fires in the RUN cycle that brings run_cycles up to the limit.
    assign w_wdog_hit  = (({1'b0, r_run_cycles} + 33'd1) >= C_WDOG_LIMIT);
    // A halt in the same cycle wins: it is a normal completion.
    assign w_wdog_fire = w_enter_flush && !bus.core_halt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog_timeout <= 1'b0;
        end else if (w_accept) begin
            r_wdog_timeout <= 1'b0;
        end else if (w_wdog_fire) begin
            r_wdog_timeout <= 1'b1;
        end
    end

    assign bus.wdog_timeout = r_wdog_timeout;
`else
    logic w_unused_wdog_limit;
    assign w_unused_wdog_limit = (WDOG_LIMIT == 0);
    assign w_wdog_hit          = 1'b0;
    assign bus.wdog_timeout    = 1'b0;
`endif

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_enter_flush = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.core_halt || w_wdog_hit) begin
                    w_enter_flush = 1'b1;
                    w_state_nxt   = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if ((w_flush_dec == 4'd0) && !bus.mem_busy) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // State and datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_adr_q      <= '0;
            r_flush_cnt  <= 4'd0;
            r_run_cycles <= 32'd0;
            r_start_drop <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_adr_q      <= bus.cpu_start_adr;
                r_run_cycles <= 32'd0;
                r_start_drop <= 1'b0;
            end else begin
                // Any start outside IDLE (including the DONE cycle) is dropped.
                if (bus.cpu_start && (r_state != S_IDLE)) begin
                    r_start_drop <= 1'b1;
                end
                if ((r_state == S_RUN) && (r_run_cycles != C_RUN_MAX)) begin
                    r_run_cycles <= r_run_cycles + 32'd1;
                end
            end

            if (w_enter_flush) begin
                r_flush_cnt <= C_FLUSH_INIT;
            end else if (r_state == S_FLUSH) begin
                r_flush_cnt <= w_flush_dec;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs: decoded from state or taken straight from registers
    //--------------------------------------------------------------------------
    assign bus.core_pc_load  = (r_state == S_LOAD);
    assign bus.core_pc_value = r_adr_q;
    assign bus.core_run      = (r_state == S_RUN);
    assign bus.cpu_end       = (r_state == S_DONE);
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.run_cycles    = r_run_cycles;
    assign bus.start_drop    = r_start_drop;

endmodule
`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_core_run_ctrl
// Description : Self-checking bench for core_run_ctrl (FLUSH_CYC=3,
//               WDOG_LIMIT=20). Jobs are described in a table; each job is
//               replayed cycle by cycle with per-cycle expected outputs queued
//               as stimulus is applied and compared after the clock edge.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_core_run_ctrl;

    localparam int PC_W = 16;

    logic clk;
    logic rst;

    core_run_ctrl_if #(.PC_W(PC_W)) bus ();

    core_run_ctrl #(
        .PC_W       (PC_W),
        .FLUSH_CYC  (3),
        .WDOG_LIMIT (20)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] adr;
        int          halt_from;
        int          halt_to;
        int          mb_low;     // mem_busy high for job cycles < mb_low
        int          drop_a;     // extra (ignored) start cycles, -1 = none
        int          drop_b;
        int          run_last;   // last job cycle with core_run=1
        int          end_cyc;    // job cycle with cpu_end=1
        logic [31:0] exp_runc;
        logic        exp_drop;
        logic        exp_wdog;
    } job_t;

    typedef struct {
        logic        load;
        logic [15:0] val;
        logic        run;
        logic        fin;
        logic        busy;
        int          cyc;
    } exp_t;

    job_t jobs[7];
    exp_t sb[$];
    int   n_checks;
    int   n_errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cpu_start     = 1'b0;
        bus.cpu_start_adr = 16'h0000;
        bus.core_halt     = 1'b0;
        bus.mem_busy      = 1'b0;
    endtask

    task automatic run_job(input int id, input job_t j);
        exp_t e;
        exp_t g;
        int   t;
        for (int c = 0; c <= j.end_cyc; c++) begin
            bus.cpu_start     = (c == 0) || (c == j.drop_a) || (c == j.drop_b);
            bus.cpu_start_adr = (c == 0) ? j.adr : 16'h0456;
            bus.core_halt     = (c >= j.halt_from) && (c <= j.halt_to);
            bus.mem_busy      = (c < j.mb_low);
            t      = c + 1;
            e.load = (t == 1);
            e.val  = j.adr;
            e.run  = (t >= 2) && (t <= j.run_last);
            e.fin  = (t == j.end_cyc);
            e.busy = (t <= j.end_cyc);
            e.cyc  = t;
            sb.push_back(e);
            @(posedge clk);
            #1;
            g = sb.pop_front();
            chk($sformatf("job%0d c%0d pc_load", id, g.cyc), 32'(bus.core_pc_load), 32'(g.load));
            chk($sformatf("job%0d c%0d pc_value", id, g.cyc), 32'(bus.core_pc_value), 32'(g.val));
            chk($sformatf("job%0d c%0d core_run", id, g.cyc), 32'(bus.core_run), 32'(g.run));
            chk($sformatf("job%0d c%0d cpu_end", id, g.cyc), 32'(bus.cpu_end), 32'(g.fin));
            chk($sformatf("job%0d c%0d busy", id, g.cyc), 32'(bus.busy), 32'(g.busy));
        end
        idle_inputs();
        chk($sformatf("job%0d run_cycles", id), bus.run_cycles, j.exp_runc);
        chk($sformatf("job%0d start_drop", id), 32'(bus.start_drop), 32'(j.exp_drop));
        chk($sformatf("job%0d wdog_timeout", id), 32'(bus.wdog_timeout), 32'(j.exp_wdog));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " pc_load"},  32'(bus.core_pc_load),  32'd0);
        chk({tag, " pc_value"}, 32'(bus.core_pc_value), 32'd0);
        chk({tag, " core_run"}, 32'(bus.core_run),      32'd0);
        chk({tag, " cpu_end"},  32'(bus.cpu_end),       32'd0);
        chk({tag, " busy"},     32'(bus.busy),          32'd0);
        chk({tag, " drop"},     32'(bus.start_drop),    32'd0);
        chk({tag, " wdog"},     32'(bus.wdog_timeout),  32'd0);
        chk({tag, " runc"},     bus.run_cycles,         32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        //            adr       hf  ht  mb  da  db  rl  end runc drop wdog
        jobs[0] = '{16'h0123, 10, 10,  0, -1, -1, 10, 14,  9, 1'b0, 1'b0};
        jobs[1] = '{16'h0ABC, 10, 10, 20, -1, -1, 10, 21,  9, 1'b0, 1'b0};
        jobs[2] = '{16'h0123,  1,  5,  0, -1, -1,  2,  6,  1, 1'b0, 1'b0};
        jobs[3] = '{16'h0123,  8,  8,  0,  5, 12,  8, 12,  7, 1'b1, 1'b0};
        jobs[4] = '{16'h0777,  3,  3,  0, -1, -1,  3,  7,  2, 1'b0, 1'b0};
        jobs[5] = '{16'h1234, 21, 21,  0, -1, -1, 21, 25, 20, 1'b0, 1'b0};
`ifdef CORE_WDOG_EN
        jobs[6] = '{16'h0BAD, -1, -1,  0, -1, -1, 21, 25, 20, 1'b0, 1'b1};
`else
        jobs[6] = '{16'h0BAD, 40, 40,  0, -1, -1, 40, 44, 39, 1'b0, 1'b0};
`endif

        // Reset state
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table of jobs, issued back to back
        for (int i = 0; i < 7; i++) begin
            run_job(i, jobs[i]);
        end

        // Asynchronous reset in the middle of RUN, with start_drop set
        bus.cpu_start     = 1'b1;
        bus.cpu_start_adr = 16'h0555;
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        bus.cpu_start = 1'b1;
        @(posedge clk);
        #1;
        bus.cpu_start = 1'b0;
        chk("pre-reset core_run", 32'(bus.core_run), 32'd1);
        chk("pre-reset start_drop", 32'(bus.start_drop), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async reset");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("reset hold %0d cpu_end", k), 32'(bus.cpu_end), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after reset busy", 32'(bus.busy), 32'd0);

        // Normal job after reset recovery
        run_job(7, jobs[0]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
